// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller:
// operand-mux select codes and the shadow pipeline-register entry layouts.
package pipe_ctrl_pkg;

  localparam int REG_AW = 5;

  // EX-stage operand mux select encoding (2'b11 is never produced)
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef struct packed {
    logic [REG_AW-1:0] rs;
    logic [REG_AW-1:0] rt;
    logic              uses_rt;
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } ex_shadow_t;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              reg_write;
    logic              mem_read;
  } mem_shadow_t;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic              reg_write;
  } wb_shadow_t;

  localparam ex_shadow_t  EX_BUBBLE  = '0;
  localparam mem_shadow_t MEM_BUBBLE = '0;
  localparam wb_shadow_t  WB_BUBBLE  = '0;

  // A stage produces a forwardable result only if it writes a nonzero register
  function automatic logic produces_result(input logic reg_write,
                                           input logic [REG_AW-1:0] dst);
    return reg_write && (dst != '0);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_fwd_select_unit.sv
// Priority compare for one EX-stage operand: the MEM-stage result beats the
// WB-stage result, and an unused operand always takes the register-file value.
module fwd_select_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic [REG_AW-1:0] mem_dst,
  input  logic              mem_reg_write,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic              wb_reg_write,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  always_comb begin
    mem_hit = produces_result(mem_reg_write, mem_dst) && (mem_dst == src);
    wb_hit  = produces_result(wb_reg_write, wb_dst) && (wb_dst == src);
  end

  always_comb begin
    sel = FWD_RF;
    if (src_used) begin
      if (mem_hit) begin
        sel = FWD_MEM;
      end else if (wb_hit) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Central hazard controller: EX operand forwarding selects, load-use stall,
// taken-branch flush, and saturating stall/flush event counters.
module hazard_forward_ctrl #(
  parameter int REG_AW = pipe_ctrl_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_uses_rt_i,
  input  logic [REG_AW-1:0] id_dst_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              branch_taken_i,
  input  logic              cnt_clr_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              pc_write_o,
  output logic              ifid_write_o,
  output logic              idex_bubble_o,
  output logic              flush_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  import pipe_ctrl_pkg::ex_shadow_t;
  import pipe_ctrl_pkg::mem_shadow_t;
  import pipe_ctrl_pkg::wb_shadow_t;
  import pipe_ctrl_pkg::EX_BUBBLE;
  import pipe_ctrl_pkg::MEM_BUBBLE;
  import pipe_ctrl_pkg::WB_BUBBLE;

  ex_shadow_t  ex_q;
  ex_shadow_t  ex_d;
  mem_shadow_t mem_q;
  wb_shadow_t  wb_q;

  logic load_use;
  logic stall_eff;
  logic flush;

  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Load in EX whose destination the ID instruction reads
  always_comb begin
    load_use = ex_q.mem_read && ex_q.reg_write && (ex_q.dst != '0) &&
               ((ex_q.dst == id_rs_i) ||
                (id_uses_rt_i && (ex_q.dst == id_rt_i)));
  end

  // A taken branch squashes the stalled instruction anyway, so flush wins
  always_comb begin
    flush     = branch_taken_i;
    stall_eff = load_use && !flush;
  end

  always_comb begin
    ex_d = EX_BUBBLE;
    if (!(stall_eff || flush)) begin
      ex_d.rs        = id_rs_i;
      ex_d.rt        = id_rt_i;
      ex_d.uses_rt   = id_uses_rt_i;
      ex_d.dst       = id_dst_i;
      ex_d.reg_write = id_reg_write_i;
      ex_d.mem_read  = id_mem_read_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_q  <= EX_BUBBLE;
      mem_q <= MEM_BUBBLE;
      wb_q  <= WB_BUBBLE;
    end else begin
      ex_q            <= ex_d;
      mem_q.dst       <= ex_q.dst;
      mem_q.reg_write <= ex_q.reg_write;
      mem_q.mem_read  <= ex_q.mem_read;
      wb_q.dst        <= mem_q.dst;
      wb_q.reg_write  <= mem_q.reg_write;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_eff && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  fwd_select_unit u_fwd_a (
    .src           (ex_q.rs),
    .src_used      (1'b1),
    .mem_dst       (mem_q.dst),
    .mem_reg_write (mem_q.reg_write),
    .wb_dst        (wb_q.dst),
    .wb_reg_write  (wb_q.reg_write),
    .sel           (forward_a_o)
  );

  fwd_select_unit u_fwd_b (
    .src           (ex_q.rt),
    .src_used      (ex_q.uses_rt),
    .mem_dst       (mem_q.dst),
    .mem_reg_write (mem_q.reg_write),
    .wb_dst        (wb_q.dst),
    .wb_reg_write  (wb_q.reg_write),
    .sel           (forward_b_o)
  );

  always_comb begin
    pc_write_o    = !stall_eff;
    ifid_write_o  = !stall_eff;
    idex_bubble_o = stall_eff;
    flush_o       = flush;
    stall_cnt_o   = stall_cnt_q;
    flush_cnt_o   = flush_cnt_q;
  end

  // The cycle after an effective stall the load has moved on into MEM
  a_load_in_mem_after_stall: assert property (
    @(posedge clk_i) disable iff (rst_i) stall_eff |=> mem_q.mem_read
  );

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed-vector bench for hazard_forward_ctrl: the driver pushes hand-computed
// expected outputs into a queue, an independent monitor pops and compares.
module tb_hazard_forward_ctrl;

  localparam int CNT_W = 2;
  localparam int W     = 8 + 2 * CNT_W;

  logic             clk;
  logic             rst;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic [4:0]       id_dst;
  logic             id_reg_write;
  logic             id_mem_read;
  logic             branch_taken;
  logic             cnt_clr;
  logic [1:0]       forward_a;
  logic [1:0]       forward_b;
  logic             pc_write;
  logic             ifid_write;
  logic             idex_bubble;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  hazard_forward_ctrl #(.REG_AW(5), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rt_i   (id_uses_rt),
    .id_dst_i       (id_dst),
    .id_reg_write_i (id_reg_write),
    .id_mem_read_i  (id_mem_read),
    .branch_taken_i (branch_taken),
    .cnt_clr_i      (cnt_clr),
    .forward_a_o    (forward_a),
    .forward_b_o    (forward_b),
    .pc_write_o     (pc_write),
    .ifid_write_o   (ifid_write),
    .idex_bubble_o  (idex_bubble),
    .flush_o        (flush),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] mon_exp;
  logic [W-1:0] mon_act;
  string        mon_name;

  function automatic logic [W-1:0] pack(input logic [1:0] fa, input logic [1:0] fb,
                                        input logic pcw, input logic ifw,
                                        input logic bub, input logic fl,
                                        input int sc, input int fc);
    return {fa, fb, pcw, ifw, bub, fl, CNT_W'(sc), CNT_W'(fc)};
  endfunction

  function automatic logic [W-1:0] norm(input logic [1:0] fa, input logic [1:0] fb,
                                        input int sc, input int fc);
    return pack(fa, fb, 1'b1, 1'b1, 1'b0, 1'b0, sc, fc);
  endfunction

  function automatic logic [W-1:0] stall_v(input int sc, input int fc);
    return pack(2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, sc, fc);
  endfunction

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic drive(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urt, input logic [4:0] dst, input logic rw,
                       input logic mr, input logic br, input logic clr);
    @(posedge clk);
    #1;
    rst          = r;
    id_rs        = rs;
    id_rt        = rt;
    id_uses_rt   = urt;
    id_dst       = dst;
    id_reg_write = rw;
    id_mem_read  = mr;
    branch_taken = br;
    cnt_clr      = clr;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                     input logic [4:0] dst);
    drive(1'b0, rs, rt, urt, dst, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] rs, input logic [4:0] dst);
    drive(1'b0, rs, 5'd0, 1'b0, dst, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic push_exp(input string nm, input logic [W-1:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: compares on the falling edge whenever an expectation is pending
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_name = name_q.pop_front();
      mon_act  = {forward_a, forward_b, pc_write, ifid_write, idex_bubble, flush,
                  stall_cnt, flush_cnt};
      checks++;
      if (mon_act !== mon_exp) begin
        errors++;
        $display("FAIL %s: got fa_fb_pcw_ifw_bub_fl_sc_fc=%b expected %b",
                 mon_name, mon_act, mon_exp);
      end
    end
  end

  initial begin
    rst = 1'b1; id_rs = '0; id_rt = '0; id_uses_rt = 1'b0; id_dst = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; branch_taken = 1'b0; cnt_clr = 1'b0;

    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    nop();               push_exp("reset_state", norm(2'b00, 2'b00, 0, 0));

    // EX/MEM forward: add $3 then sub reading $3
    alu(5'd1, 5'd2, 1'b1, 5'd3); push_exp("idle_no_fwd", norm(2'b00, 2'b00, 0, 0));
    alu(5'd3, 5'd4, 1'b1, 5'd6);
    nop();               push_exp("fwd_mem_a", norm(2'b10, 2'b00, 0, 0));
    nop();

    // Producer one slot further back -> MEM/WB select on both operands
    alu(5'd1, 5'd2, 1'b1, 5'd3);
    alu(5'd7, 5'd8, 1'b1, 5'd9);
    alu(5'd3, 5'd3, 1'b1, 5'd11);
    nop();               push_exp("fwd_wb_ab", norm(2'b01, 2'b01, 0, 0));

    // Two $3 producers in flight: the younger (MEM) wins
    alu(5'd1, 5'd2, 1'b1, 5'd3);
    alu(5'd1, 5'd2, 1'b1, 5'd3);
    alu(5'd3, 5'd5, 1'b1, 5'd12);
    nop();               push_exp("fwd_mem_over_wb", norm(2'b10, 2'b00, 0, 0));

    // Register 0 never forwards
    alu(5'd1, 5'd2, 1'b1, 5'd0);
    alu(5'd0, 5'd0, 1'b1, 5'd13);
    nop();               push_exp("reg0_never_fwd", norm(2'b00, 2'b00, 0, 0));

    // rt match with uses_rt=0 gives no B forward
    alu(5'd1, 5'd2, 1'b1, 5'd4);
    alu(5'd7, 5'd4, 1'b0, 5'd14);
    nop();               push_exp("uses_rt_off", norm(2'b00, 2'b00, 0, 0));

    // Load-use: one stall cycle, then the consumer gets the WB result
    lw(5'd1, 5'd5);
    alu(5'd5, 5'd6, 1'b1, 5'd7); push_exp("load_use_stall", stall_v(0, 0));
    alu(5'd5, 5'd6, 1'b1, 5'd7); push_exp("load_use_release", norm(2'b00, 2'b00, 1, 0));
    nop();               push_exp("load_use_fwd_wb", norm(2'b01, 2'b00, 1, 0));

    // Branch taken in the same cycle as a load-use hazard
    lw(5'd1, 5'd5);
    drive(1'b0, 5'd5, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp("branch_beats_stall", pack(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1, 0));
    nop();               push_exp("flush_counted", norm(2'b00, 2'b00, 1, 1));

    // Counter clear
    drive(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    nop();               push_exp("cnt_clear", norm(2'b00, 2'b00, 0, 0));

    // Five stalls saturate a 2-bit counter at 3
    for (int k = 0; k < 5; k++) begin
      lw(5'd1, 5'd5);
      alu(5'd5, 5'd6, 1'b1, 5'd7);
      push_exp($sformatf("sat_stall_%0d", k), stall_v((k < 3) ? k : 3, 0));
      alu(5'd5, 5'd6, 1'b1, 5'd7);
      push_exp($sformatf("sat_release_%0d", k),
               norm(2'b00, 2'b00, (k + 1 < 3) ? k + 1 : 3, 0));
    end

    // Clear during a stall cycle beats the increment
    lw(5'd1, 5'd5);
    drive(1'b0, 5'd5, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
    push_exp("clr_in_stall", stall_v(3, 0));
    alu(5'd5, 5'd6, 1'b1, 5'd7); push_exp("clr_beats_inc", norm(2'b00, 2'b00, 0, 0));

    // Reset mid-stall cancels the stall next cycle
    lw(5'd1, 5'd5);
    drive(1'b1, 5'd5, 5'd6, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    push_exp("stall_before_rst", stall_v(0, 0));
    alu(5'd5, 5'd6, 1'b1, 5'd7); push_exp("rst_cancels_stall", norm(2'b00, 2'b00, 0, 0));
    nop();
    nop();

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
